control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_ctrl_pkg.sv | 101 ++++++++++
 rtl/control_unit_if.sv | 15 +
 rtl/ctrl_decode.sv | 129 ++++++++++++
 rtl/control_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit and the DataPath ALU:
// opcodes, ALU operation codes, FSM states and the control-vector layout.
package cpu_ctrl_pkg;

  // Instruction opcodes, IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes driven on the opcode output (same encoding as ALU-R)
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_MUL  = 5'b01111;
  localparam logic [4:0] ALU_DIV  = 5'b10000;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALTED
  } cu_state_e;

  typedef enum logic [3:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_ALUR, CLS_ALUI,
    CLS_MULDIV, CLS_BR, CLS_NOP, CLS_HALT, CLS_ILL
  } instr_class_e;

  typedef struct packed {
    logic       PCout;
    logic       Zhighout;
    logic       Zlowout;
    logic       MDRout;
    logic       Cout;
    logic       Rout;
    logic       BAout;
    logic       MARin;
    logic       PCin;
    logic       MDRin;
    logic       IRin;
    logic       Yin;
    logic       ZHighIn;
    logic       ZLowIn;
    logic       HIin;
    logic       LOin;
    logic       Rin;
    logic       CONin;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       IncPC;
    logic       Read;
    logic       Write;
    logic [4:0] opcode;
    logic       run;
    logic       illegal;
  } ctrl_t;

  function automatic instr_class_e classify(input logic [4:0] op);
    instr_class_e cls;
    if (op == OP_LD)                          cls = CLS_LD;
    else if (op == OP_LDI)                    cls = CLS_LDI;
    else if (op == OP_ST)                     cls = CLS_ST;
    else if (op >= OP_ADD && op <= OP_ROL)    cls = CLS_ALUR;
    else if (op >= OP_ADDI && op <= OP_ORI)   cls = CLS_ALUI;
    else if (op == OP_MUL || op == OP_DIV)    cls = CLS_MULDIV;
    else if (op == OP_BR)                     cls = CLS_BR;
    else if (op == OP_NOP)                    cls = CLS_NOP;
    else if (op == OP_HALT)                   cls = CLS_HALT;
    else                                      cls = CLS_ILL;
    return cls;
  endfunction

  // Immediate forms reuse the register-form ALU operation
  function automatic logic [4:0] alu_imm_op(input logic [4:0] op);
    logic [4:0] alu;
    case (op)
      OP_ANDI: alu = ALU_AND;
      OP_ORI:  alu = ALU_OR;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Link between the control-unit FSM and its output decoder: FSM state and
// decode inputs in one direction, the decoded control vector in the other.
interface control_unit_if;
  import cpu_ctrl_pkg::*;

  cu_state_e  state;
  logic [4:0] ir_op;
  logic [4:0] op_q;
  logic       con_ff;
  logic       last_wait;
  ctrl_t      ctrl;

  modport master (input state, ir_op, op_q, con_ff, last_wait, output ctrl);
  modport slave  (output state, ir_op, op_q, con_ff, last_wait, input ctrl);
endinterface

// File: rtl/ctrl_decode.sv
// Moore output decoder: control vector from FSM state and latched opcode.
// The live IR is looked at only in T3 and CON_FF only in T6.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  control_unit_if.master bus
);

  logic [4:0]   op;
  instr_class_e cls;
  ctrl_t        c;

  // In T3 the latched opcode is still the previous instruction's
  assign op  = (bus.state == T3) ? bus.ir_op : bus.op_q;
  assign cls = classify(op);

  always_comb begin
    c = '0;
    c.run = (bus.state != RST) && (bus.state != HALTED);
    case (bus.state)
      T0: begin
        c.PCout  = 1'b1;
        c.MARin  = 1'b1;
        c.IncPC  = 1'b1;
        c.ZLowIn = 1'b1;
      end
      T1: begin
        c.Read  = 1'b1;
        c.MDRin = 1'b1;
        if (bus.last_wait) begin
          c.Zlowout = 1'b1;
          c.PCin    = 1'b1;
        end
      end
      T2: begin
        c.MDRout = 1'b1;
        c.IRin   = 1'b1;
      end
      T3: begin
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST: begin
            c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1;
          end
          CLS_ALUR, CLS_ALUI: begin
            c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1;
          end
          CLS_MULDIV: begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1;
          end
          CLS_BR: begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1;
          end
          CLS_ILL: c.illegal = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST: begin
            c.Cout = 1'b1; c.opcode = ALU_ADD; c.ZLowIn = 1'b1;
          end
          CLS_ALUR: begin
            c.Grc = 1'b1; c.Rout = 1'b1; c.opcode = op; c.ZLowIn = 1'b1;
          end
          CLS_ALUI: begin
            c.Cout = 1'b1; c.opcode = alu_imm_op(op); c.ZLowIn = 1'b1;
          end
          CLS_MULDIV: begin
            c.Grb = 1'b1; c.Rout = 1'b1; c.opcode = op;
            c.ZLowIn = 1'b1; c.ZHighIn = 1'b1;
          end
          CLS_BR: begin
            c.PCout = 1'b1; c.Yin = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_LD, CLS_ST: begin
            c.Zlowout = 1'b1; c.MARin = 1'b1;
          end
          CLS_LDI, CLS_ALUR, CLS_ALUI: begin
            c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end
          CLS_MULDIV: begin
            c.Zlowout = 1'b1; c.LOin = 1'b1;
          end
          CLS_BR: begin
            c.Cout = 1'b1; c.opcode = ALU_ADD; c.ZLowIn = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CLS_LD: begin
            c.Read = 1'b1; c.MDRin = 1'b1;
          end
          CLS_ST: begin
            c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1;
          end
          CLS_MULDIV: begin
            c.Zhighout = 1'b1; c.HIin = 1'b1;
          end
          CLS_BR: begin
            if (bus.con_ff) begin
              c.Zlowout = 1'b1; c.PCin = 1'b1;
            end
          end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          CLS_LD: begin
            c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
          end
          CLS_ST: c.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.ctrl = c;

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: fetch/execute Moore FSM with a memory-read wait
// counter; the output decode lives in ctrl_decode.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int READ_WAIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        Rout,
  output logic        BAout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  opcode,
  output logic        run,
  output logic        illegal,
  output cu_state_e   dbg_state
);

  cu_state_e    state_q, state_d;
  logic [2:0]   wait_q, wait_d;
  logic [4:0]   op_q, op_d;
  logic         wait_done;
  instr_class_e cls_live, cls_q;
  logic         unused_ir;

  control_unit_if u_if ();

  assign wait_done = (wait_q == 3'(READ_WAIT));
  assign cls_live  = classify(IR[31:27]);
  assign cls_q     = classify(op_q);
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= RST;
      wait_q  <= '0;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
    end
  end

  // The wait counter only runs while a memory-read state is being stretched
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    op_d    = op_q;
    case (state_q)
      RST: state_d = T0;
      T0:  state_d = T1;
      T1: begin
        if (wait_done) state_d = T2;
        else           wait_d  = wait_q + 3'd1;
      end
      T2:  state_d = T3;
      T3: begin
        op_d = IR[31:27];
        case (cls_live)
          CLS_HALT:         state_d = HALTED;
          CLS_NOP, CLS_ILL: state_d = T0;
          default:          state_d = T4;
        endcase
      end
      T4:  state_d = T5;
      T5: begin
        case (cls_q)
          CLS_LD, CLS_ST, CLS_MULDIV, CLS_BR: state_d = T6;
          default:                            state_d = T0;
        endcase
      end
      T6: begin
        if (cls_q == CLS_LD && !wait_done)           wait_d  = wait_q + 3'd1;
        else if (cls_q == CLS_LD || cls_q == CLS_ST) state_d = T7;
        else                                         state_d = T0;
      end
      T7:      state_d = T0;
      HALTED:  state_d = HALTED;
      default: state_d = RST;
    endcase
  end

  assign u_if.state     = state_q;
  assign u_if.ir_op     = IR[31:27];
  assign u_if.op_q      = op_q;
  assign u_if.con_ff    = CON_FF;
  assign u_if.last_wait = wait_done;

  ctrl_decode u_decode (.bus(u_if.master));

  assign PCout     = u_if.ctrl.PCout;
  assign Zhighout  = u_if.ctrl.Zhighout;
  assign Zlowout   = u_if.ctrl.Zlowout;
  assign MDRout    = u_if.ctrl.MDRout;
  assign Cout      = u_if.ctrl.Cout;
  assign Rout      = u_if.ctrl.Rout;
  assign BAout     = u_if.ctrl.BAout;
  assign MARin     = u_if.ctrl.MARin;
  assign PCin      = u_if.ctrl.PCin;
  assign MDRin     = u_if.ctrl.MDRin;
  assign IRin      = u_if.ctrl.IRin;
  assign Yin       = u_if.ctrl.Yin;
  assign ZHighIn   = u_if.ctrl.ZHighIn;
  assign ZLowIn    = u_if.ctrl.ZLowIn;
  assign HIin      = u_if.ctrl.HIin;
  assign LOin      = u_if.ctrl.LOin;
  assign Rin       = u_if.ctrl.Rin;
  assign CONin     = u_if.ctrl.CONin;
  assign Gra       = u_if.ctrl.Gra;
  assign Grb       = u_if.ctrl.Grb;
  assign Grc       = u_if.ctrl.Grc;
  assign IncPC     = u_if.ctrl.IncPC;
  assign Read      = u_if.ctrl.Read;
  assign Write     = u_if.ctrl.Write;
  assign opcode    = u_if.ctrl.opcode;
  assign run       = u_if.ctrl.run;
  assign illegal   = u_if.ctrl.illegal;
  assign dbg_state = state_q;

endmodule
